// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 transmitter. Performs request-to-send, shifts
//            out one command byte with odd parity on device-generated clock
//            edges, checks the device ACK and guards every phase with a
//            watchdog. tx_idle gates the companion receiver.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drv_low,
  output logic       ps2d_drv_low,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  // Shared counter covers both the RTS hold time and the watchdog window.
  localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_RTS      = 3'd1;
  localparam logic [2:0] c_ST_START    = 3'd2;
  localparam logic [2:0] c_ST_DATA     = 3'd3;
  localparam logic [2:0] c_ST_STOP     = 3'd4;
  localparam logic [2:0] c_ST_ACK      = 3'd5;
  localparam logic [2:0] c_ST_WAIT_REL = 3'd6;

  // Clock glitch filter and data-line synchroniser
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_f_ps2c;
  logic                  w_f_ps2c_next;
  logic                  w_fall;
  logic                  r_ps2d_meta;
  logic                  r_ps2d;

  // Control state and datapath
  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [8:0]         r_frame;
  logic [8:0]         w_frame_next;
  logic [3:0]         r_bit_cnt;
  logic [3:0]         w_bit_cnt_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic               r_done_tick;
  logic               w_done_next;
  logic               r_err_tick;
  logic               w_err_next;
  logic               w_timeout;

  // Shift the raw pad clock into the filter; double-register the data pad.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt      <= '1;
      r_f_ps2c    <= 1'b1;
      r_ps2d_meta <= 1'b1;
      r_ps2d      <= 1'b1;
    end else begin
      r_filt      <= {ps2c_in, r_filt[FILTER_LEN-1:1]};
      r_f_ps2c    <= w_f_ps2c_next;
      r_ps2d_meta <= ps2d_in;
      r_ps2d      <= r_ps2d_meta;
    end
  end

  // Filtered clock only changes once the whole window agrees.
  always_comb begin
    w_f_ps2c_next = r_f_ps2c;
    if (r_filt == '1) begin
      w_f_ps2c_next = 1'b1;
    end else if (r_filt == '0) begin
      w_f_ps2c_next = 1'b0;
    end
  end

  assign w_fall = r_f_ps2c & ~w_f_ps2c_next;

  // A fall in the same cycle as expiry rescues the frame.
  assign w_timeout = ~w_fall & (r_cnt == c_TIMEOUT_LAST);

  // State register plus frame, bit counter, shared counter and tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_IDLE;
      r_frame     <= '0;
      r_bit_cnt   <= '0;
      r_cnt       <= '0;
      r_done_tick <= 1'b0;
      r_err_tick  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame     <= w_frame_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_cnt       <= w_cnt_next;
      r_done_tick <= w_done_next;
      r_err_tick  <= w_err_next;
    end
  end

  // Next-state, datapath update and completion tick decisions.
  always_comb begin
    w_state_next   = r_state;
    w_frame_next   = r_frame;
    w_bit_cnt_next = r_bit_cnt;
    w_cnt_next     = r_cnt;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_cnt_next = '0;
        if (wr_ps2) begin
          w_frame_next = {~^din, din};
          w_state_next = c_ST_RTS;
        end
      end
      c_ST_RTS: begin
        if (r_cnt == c_INHIBIT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = c_ST_START;
        end else begin
          w_cnt_next = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        // Device-clocked phases: watchdog restarts on every filtered fall.
        w_cnt_next = w_fall ? '0 : r_cnt + c_CNT_ONE;
        if (w_timeout) begin
          w_state_next = c_ST_IDLE;
          w_err_next   = 1'b1;
        end else begin
          case (r_state)
            c_ST_START: begin
              if (w_fall) begin
                w_state_next   = c_ST_DATA;
                w_bit_cnt_next = 4'd8;
              end
            end
            c_ST_DATA: begin
              if (w_fall) begin
                if (r_bit_cnt == 4'd0) begin
                  w_state_next = c_ST_STOP;
                end else begin
                  w_frame_next   = {1'b0, r_frame[8:1]};
                  w_bit_cnt_next = r_bit_cnt - 4'd1;
                end
              end
            end
            c_ST_STOP: begin
              if (w_fall) begin
                w_state_next = c_ST_ACK;
              end
            end
            c_ST_ACK: begin
              if (w_fall) begin
                if (!r_ps2d) begin
                  w_state_next = c_ST_WAIT_REL;
                end else begin
                  w_state_next = c_ST_IDLE;
                  w_err_next   = 1'b1;
                end
              end
            end
            c_ST_WAIT_REL: begin
              if (r_f_ps2c && r_ps2d) begin
                w_state_next = c_ST_IDLE;
                w_done_next  = 1'b1;
              end
            end
            default: begin
              w_state_next = c_ST_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Moore pad drivers and idle flag, decoded from state and frame only.
  always_comb begin
    ps2c_drv_low = 1'b0;
    ps2d_drv_low = 1'b0;
    tx_idle      = 1'b0;
    case (r_state)
      c_ST_IDLE:  tx_idle      = 1'b1;
      c_ST_RTS:   ps2c_drv_low = 1'b1;
      c_ST_START: ps2d_drv_low = 1'b1;
      c_ST_DATA:  ps2d_drv_low = ~r_frame[0];
      default:    ps2d_drv_low = 1'b0;
    endcase
  end

  assign tx_done_tick = r_done_tick;
  assign tx_err_tick  = r_err_tick;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with an open-drain PS/2
//            device model, table-driven and randomized frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TO   = 1000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b0;
  logic       dev_d = 1'b0;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_drv_low;
  logic       ps2d_drv_low;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;

  // Open-drain lines with pull-ups: low if either side pulls.
  assign ps2c_in = ~(ps2c_drv_low | dev_c);
  assign ps2d_in = ~(ps2d_drv_low | dev_d);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_drv_low(ps2c_drv_low),
    .ps2d_drv_low(ps2d_drv_low),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    bit          ack;
    bit          glitch;
    bit          busy;
    logic [10:0] exp_bits;
    int          exp_done;
    int          exp_err;
  } vec_t;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line image of a host frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Tick monitor: count pulses and check they coincide with IDLE, never both.
  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (tx_err_tick) err_cnt++;
    if (tx_done_tick || tx_err_tick) begin
      check("tick_with_idle", {31'd0, tx_idle}, 32'd1);
      check("ticks_exclusive", {31'd0, tx_done_tick & tx_err_tick}, 32'd0);
    end
  end

  // Device clock pulse: optional short glitch in the high phase, sample data, pull low.
  task automatic dev_pulse(input bit glitch, output bit smp);
    if (glitch) begin
      cycles(15);
      dev_c = 1'b1;
      cycles(3);
      dev_c = 1'b0;
      cycles(HALF - 18);
    end else begin
      cycles(HALF);
    end
    smp   = ps2d_in;
    dev_c = 1'b1;
    cycles(HALF);
    dev_c = 1'b0;
  endtask

  // Strobe a byte and measure how long the clock is inhibited.
  task automatic start_tx(input logic [7:0] b, input string tag);
    int rts;
    done_cnt = 0;
    err_cnt  = 0;
    din    = b;
    wr_ps2 = 1'b1;
    cycles(1);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
    rts = 0;
    while (ps2c_drv_low && rts < INH + 10) begin
      rts++;
      cycles(1);
    end
    check({tag, "_rts_len"}, rts, INH);
    check({tag, "_start_pads"}, {30'd0, ps2c_drv_low, ps2d_drv_low}, 32'b01);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    bit smp;
    logic [10:0] bits;
    int k;
    start_tx(v.din, tag);
    fork
      begin
        for (int i = 0; i < 11; i++) begin
          dev_pulse(v.glitch && (i == 4), smp);
          bits[i] = smp;
        end
        if (v.ack) dev_d = 1'b1;
        dev_pulse(1'b0, smp);
        cycles(HALF);
        dev_d = 1'b0;
      end
      begin
        if (v.busy) begin
          cycles(6 * 2 * HALF);
          din    = 8'h00;
          wr_ps2 = 1'b1;
          cycles(1);
          wr_ps2 = 1'b0;
        end
      end
    join
    k = 0;
    while (!tx_idle && k < 200) begin
      k++;
      cycles(1);
    end
    cycles(5);
    check({tag, "_bits"}, {21'd0, bits}, {21'd0, v.exp_bits});
    check({tag, "_done_cnt"}, done_cnt, v.exp_done);
    check({tag, "_err_cnt"}, err_cnt, v.exp_err);
    check({tag, "_end_pads_idle"}, {29'd0, ps2c_drv_low, ps2d_drv_low, tx_idle}, 32'b001);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    bit smp;
    int k;

    vecs[0] = '{din: 8'hED, ack: 1'b1, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_1_11101101_0, exp_done: 1, exp_err: 0};
    vecs[1] = '{din: 8'hF4, ack: 1'b1, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_0_11110100_0, exp_done: 1, exp_err: 0};
    vecs[2] = '{din: 8'hFF, ack: 1'b0, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_1_11111111_0, exp_done: 0, exp_err: 1};
    vecs[3] = '{din: 8'h00, ack: 1'b1, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_1_00000000_0, exp_done: 1, exp_err: 0};
    vecs[4] = '{din: 8'h01, ack: 1'b1, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_0_00000001_0, exp_done: 1, exp_err: 0};
    vecs[5] = '{din: 8'hED, ack: 1'b1, glitch: 1'b1, busy: 1'b1,
                exp_bits: 11'b1_1_11101101_0, exp_done: 1, exp_err: 0};

    // Reset state
    cycles(3);
    check("reset_outputs", {27'd0, ps2c_drv_low, ps2d_drv_low, tx_idle, tx_done_tick, tx_err_tick},
          32'b00100);
    rst = 1'b1;
    cycles(3);
    check("post_reset_idle", {29'd0, ps2c_drv_low, ps2d_drv_low, tx_idle}, 32'b001);

    // Table-driven frames
    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("tab%0d", i));

    // Randomized frames against the reference model
    for (int i = 0; i < 10; i++) begin
      rv.din      = 8'($urandom);
      rv.ack      = ($urandom_range(0, 4) != 0);
      rv.glitch   = 1'b0;
      rv.busy     = 1'b0;
      rv.exp_bits = ref_frame(rv.din);
      rv.exp_done = rv.ack ? 1 : 0;
      rv.exp_err  = rv.ack ? 0 : 1;
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    // Silent device: error tick exactly TO cycles after START entry
    start_tx(8'hAA, "silent");
    k = 0;
    while (!tx_err_tick && k < TO + 50) begin
      cycles(1);
      k++;
    end
    check("silent_timeout_cycles", k, TO);
    cycles(3);
    check("silent_err_cnt", err_cnt, 1);
    check("silent_done_cnt", done_cnt, 0);
    check("silent_pads_idle", {29'd0, ps2c_drv_low, ps2d_drv_low, tx_idle}, 32'b001);

    // Reset during DATA bit 4 (0x0F has bit 4 = 0, so data is being pulled)
    start_tx(8'h0F, "rstmid");
    for (int i = 0; i < 5; i++) dev_pulse(1'b0, smp);
    check("rstmid_bit4_drive", {30'd0, ps2c_drv_low, ps2d_drv_low}, 32'b01);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_async_release", {29'd0, ps2c_drv_low, ps2d_drv_low, tx_idle}, 32'b001);
    cycles(3);
    rst = 1'b1;
    cycles(5);
    rv = vecs[1];
    run_frame(rv, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
